// File: rtl/instr_mem_loader_if.sv
`timescale 1ns/1ps
// Instruction-memory loader bus: load control, incoming byte stream and
// the word-write port into the instruction memory.
interface instr_mem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  start;
  logic [ADDR_WIDTH:0]   wordCount;
  logic                  byteValid;
  logic [7:0]            byteData;
  logic                  byteReady;
  logic                  memWriteEnable;
  logic [ADDR_WIDTH-1:0] memWriteAddress;
  logic [31:0]           memWriteData;
  logic                  busy;
  logic                  done;
  logic                  error;

  // Host / byte source side
  modport master (
    output start, wordCount, byteValid, byteData,
    input  byteReady, memWriteEnable, memWriteAddress, memWriteData,
    input  busy, done, error
  );

  // Loader side
  modport slave (
    input  start, wordCount, byteValid, byteData,
    output byteReady, memWriteEnable, memWriteAddress, memWriteData,
    output busy, done, error
  );
endinterface

// File: rtl/instr_mem_loader.sv
`timescale 1ns/1ps
// Instruction memory write side: packs a byte stream into little-endian
// 32-bit words and writes them to consecutive word addresses from 0.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_mem_loader_if.slave bus
);
  localparam int unsigned CountWidth = ADDR_WIDTH + 1;
  localparam int unsigned Depth      = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic [CountWidth-1:0]  count;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [1:0]             byteIdx;
  // Lower three bytes of the word; the fourth goes straight into memWriteData.
  logic [23:0]            lowBytes;

  logic                   byteReady;
  logic                   memWriteEnable;
  logic [ADDR_WIDTH-1:0]  memWriteAddress;
  logic [31:0]            memWriteData;
  logic                   busy;
  logic                   done;
  logic                   error;

  logic                   lastWord;

  assign lastWord = ({1'b0, addr} == (count - CountWidth'(1)));

  // Loader FSM with registered outputs set on entry to each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      count           <= '0;
      addr            <= '0;
      byteIdx         <= '0;
      lowBytes        <= '0;
      byteReady       <= 1'b0;
      memWriteEnable  <= 1'b0;
      memWriteAddress <= '0;
      memWriteData    <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      memWriteEnable <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.wordCount == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (bus.wordCount > CountWidth'(Depth)) begin
              error <= 1'b1;
            end else begin
              count     <= bus.wordCount;
              addr      <= '0;
              byteIdx   <= '0;
              lowBytes  <= '0;
              byteReady <= 1'b1;
              busy      <= 1'b1;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (bus.byteValid) begin
            byteIdx <= byteIdx + 2'd1;
            case (byteIdx)
              2'd0: lowBytes[7:0]   <= bus.byteData;
              2'd1: lowBytes[15:8]  <= bus.byteData;
              2'd2: lowBytes[23:16] <= bus.byteData;
              default: begin
                memWriteEnable  <= 1'b1;
                memWriteAddress <= addr;
                memWriteData    <= {bus.byteData, lowBytes};
                byteReady       <= 1'b0;
                state           <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          if (lastWord) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            addr      <= addr + ADDR_WIDTH'(1);
            byteReady <= 1'b1;
            state     <= LOAD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.byteReady       = byteReady;
  assign bus.memWriteEnable  = memWriteEnable;
  assign bus.memWriteAddress = memWriteAddress;
  assign bus.memWriteData    = memWriteData;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.error           = error;

endmodule

// File: tb/tb_instr_mem_loader.sv
`timescale 1ns/1ps
// Randomized bench for instr_mem_loader against a cycle-level protocol model
// built from byte queues and little-endian word packing.
module tb_instr_mem_loader;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk;
  logic rst_n;

  instr_mem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] lastAddr;
  logic [31:0] lastData;
  logic [7:0]  fixedBytes[$];

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against expectations; write port must hold between strobes.
  task automatic checkOutputs(input bit eReady, input bit eWrite, input bit eDone,
                              input bit eBusy, input bit eError,
                              input logic [31:0] eAddr, input logic [31:0] eData);
    checkValue("byteReady", 32'(bus.byteReady), 32'(eReady));
    checkValue("memWriteEnable", 32'(bus.memWriteEnable), 32'(eWrite));
    checkValue("done", 32'(bus.done), 32'(eDone));
    checkValue("busy", 32'(bus.busy), 32'(eBusy));
    checkValue("error", 32'(bus.error), 32'(eError));
    if (eWrite) begin
      lastAddr = eAddr;
      lastData = eData;
    end
    checkValue("memWriteAddress", 32'(bus.memWriteAddress), lastAddr);
    checkValue("memWriteData", bus.memWriteData, lastData);
  endtask

  // gap: 0 = byte every cycle, 1 = every 3rd cycle, 2 = random.
  // poke: pulse start with a random count during the load; it must be ignored.
  task automatic runLoad(input int count, input int gap, input bit poke);
    logic [7:0]  bytes[$];
    logic [31:0] expWords[$];
    int nBytes;
    int sent, acc, wIdx, cyc;
    bit eReady, eWrite, eDone, eBusy;
    bit nReady, nWrite, nDone, nBusy;
    bit valid, fin;
    nBytes = count * 4;
    sent = 0; acc = 0; wIdx = 0; cyc = 0; fin = 1'b0;
    for (int i = 0; i < nBytes; i++) begin
      if (fixedBytes.size() > 0) bytes.push_back(fixedBytes.pop_front());
      else bytes.push_back(8'($urandom_range(0, 255)));
    end
    for (int w = 0; w < count; w++)
      expWords.push_back({bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]});

    @(negedge clk);
    bus.start     = 1'b1;
    bus.wordCount = 6'(count);
    bus.byteValid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    eReady = 1'b1; eWrite = 1'b0; eDone = 1'b0; eBusy = 1'b1;
    checkOutputs(eReady, eWrite, eDone, eBusy, 1'b0, 32'h0, 32'h0);

    while (!fin) begin
      valid = (sent < nBytes) &&
              ((gap == 0) || (gap == 1 && (cyc % 3) == 0) ||
               (gap == 2 && $urandom_range(0, 2) != 0));
      bus.byteValid = valid;
      bus.byteData  = valid ? bytes[sent] : 8'($urandom);
      bus.start     = poke && (cyc == 2 || cyc == 7 || cyc == 11);
      bus.wordCount = 6'($urandom_range(0, 63));

      nReady = eReady; nWrite = 1'b0; nDone = 1'b0; nBusy = eBusy;
      if (eDone) fin = 1'b1;
      if (eReady && valid) begin
        sent++;
        acc++;
        if (acc == 4) begin
          acc    = 0;
          nReady = 1'b0;
          nWrite = 1'b1;
        end
      end
      if (eWrite) begin
        wIdx++;
        if (wIdx == count) begin
          nDone = 1'b1;
          nBusy = 1'b0;
        end else begin
          nReady = 1'b1;
        end
      end

      @(negedge clk);
      cyc++;
      eReady = nReady; eWrite = nWrite; eDone = nDone; eBusy = nBusy;
      checkOutputs(eReady, eWrite, eDone, eBusy, 1'b0, 32'(wIdx),
                   eWrite ? expWords[wIdx] : 32'h0);
      if (cyc > 4000) begin
        checkValue("loadTimeout", 32'(cyc), 32'h0);
        fin = 1'b1;
      end
    end
    bus.byteValid = 1'b0;
    bus.start     = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.wordCount = '0;
    bus.byteValid = 1'b0;
    bus.byteData  = '0;
    lastAddr      = '0;
    lastData      = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;

    // Reset mid-load after two bytes discards the partial word
    @(negedge clk);
    bus.start = 1'b1; bus.wordCount = 6'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.byteValid = 1'b1; bus.byteData = 8'hAA;
    @(negedge clk);
    bus.byteData = 8'hBB;
    @(negedge clk);
    bus.byteValid = 1'b0;
    checkValue("midLoadBusy", 32'(bus.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fixedBytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    runLoad(1, 0, 1'b0);
    checkValue("postResetWord", bus.memWriteData, 32'h44332211);

    // Single word, known instruction
    fixedBytes = '{8'h13, 8'h00, 8'hA0, 8'hE3};
    runLoad(1, 0, 1'b0);
    checkValue("exampleWord", bus.memWriteData, 32'hE3A00013);

    // Two words with sparse byteValid
    runLoad(2, 1, 1'b0);

    // Full depth, no wrap past the last address
    runLoad(DEPTH, 0, 1'b0);
    checkValue("lastAddr", 32'(bus.memWriteAddress), 32'(DEPTH - 1));

    // Zero-length load: done next cycle, no write
    @(negedge clk);
    bus.start = 1'b1; bus.wordCount = 6'd0;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutputs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Oversized count: error pulse, stays idle, bytes offered are refused
    bus.start = 1'b1; bus.wordCount = 6'(DEPTH + 1);
    bus.byteValid = 1'b1; bus.byteData = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.byteData = 8'($urandom);
      @(negedge clk);
      checkOutputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    bus.byteValid = 1'b0;

    // Start pulses during a load are ignored
    runLoad(3, 0, 1'b1);

    // Randomized loads
    repeat (6) runLoad($urandom_range(1, DEPTH), 2, 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
